// File: rtl/fofb_mac_accum.sv
// FOFB multiply-accumulate stage: dot product of BPM errors and matrix coefficients
// over one valid window, producing a shifted, saturated correction word.
module fofb_mac_accum #(
  parameter int DATA_W = 32,
  parameter int COEF_W = 18,
  parameter int ACC_W  = 64,
  parameter int OUT_W  = 32,
  parameter int SHIFT  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fofbCalStart,
  input  logic              data_valid,
  input  logic [DATA_W-1:0] bpm_data,
  input  logic [COEF_W-1:0] coef_data,
  input  logic [8:0]        CalcLanth,
  output logic [OUT_W-1:0]  result,
  output logic              result_valid,
  output logic [9:0]        sample_count,
  output logic              length_err,
  output logic              busy
);

  localparam int PROD_W = DATA_W + COEF_W;

  localparam logic signed [ACC_W-1:0] OUT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] OUT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    ACCUM,
    FLUSH,
    DONE
  } state_t;

  state_t state, stateNext;

  logic                     startQ;
  logic                     startEvent;
  logic                     flushCnt;
  logic                     capture;
  logic                     clearRun;
  logic signed [PROD_W-1:0] prodNext;
  logic signed [PROD_W-1:0] prodReg;
  logic                     prodValid;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  shifted;
  logic [OUT_W-1:0]         satNext;
  logic [9:0]               count;
  logic [9:0]               expCount;

  assign startEvent   = fofbCalStart & ~startQ;
  assign prodNext     = $signed(bpm_data) * $signed(coef_data);
  assign shifted      = acc >>> SHIFT;
  assign expCount     = {1'b0, CalcLanth} + 10'd1;
  assign busy         = (state != IDLE);
  assign sample_count = count;

  // NOTE: every combinational output gets a default before the case so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    stateNext = state;
    capture   = 1'b0;
    clearRun  = 1'b0;
    case (state)
      IDLE:  stateNext = IDLE;
      ARMED: if (data_valid) begin
               stateNext = ACCUM;
               capture   = 1'b1;
             end
      ACCUM: if (data_valid) capture = 1'b1;
             else            stateNext = FLUSH;
      FLUSH: if (flushCnt) stateNext = DONE;
      DONE:  stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
    // A start event re-arms from any state, dropping whatever run is in flight.
    if (startEvent) begin
      stateNext = ARMED;
      capture   = 1'b0;
      clearRun  = 1'b1;
    end
  end

  always_comb begin
    satNext = shifted[OUT_W-1:0];
    if (shifted > OUT_MAX)      satNext = OUT_MAX[OUT_W-1:0];
    else if (shifted < OUT_MIN) satNext = OUT_MIN[OUT_W-1:0];
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      startQ   <= 1'b0;
      flushCnt <= 1'b0;
    end else begin
      state    <= stateNext;
      startQ   <= fofbCalStart;
      flushCnt <= (state == FLUSH) ? ~flushCnt : 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prodReg      <= '0;
      prodValid    <= 1'b0;
      acc          <= '0;
      count        <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      length_err   <= 1'b0;
    end else begin
      prodValid <= capture;
      if (capture) prodReg <= prodNext;

      if (clearRun) begin
        acc   <= '0;
        count <= '0;
      end else if (prodValid) begin
        acc <= acc + {{(ACC_W-PROD_W){prodReg[PROD_W-1]}}, prodReg};
        if (count != 10'h3FF) count <= count + 10'd1;
      end

      result_valid <= (state == DONE);
      if (state == DONE) begin
        result     <= satNext;
        length_err <= (count != expCount);
      end else if (clearRun && state == IDLE) begin
        length_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fofb_mac_accum.sv
// Scoreboard bench for fofb_mac_accum: two instances (SHIFT=0 and SHIFT=16) share
// stimulus; expected results are queued per run and popped on result_valid.
module tb_fofb_mac_accum;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fofbCalStart = 1'b0;
  logic        data_valid = 1'b0;
  logic [31:0] bpm_data = '0;
  logic [17:0] coef_data = '0;
  logic [8:0]  CalcLanth = '0;

  logic [31:0] result0, result16;
  logic        rv0, rv16;
  logic [9:0]  count0, count16;
  logic        err0, err16;
  logic        busy0, busy16;

  typedef struct {
    logic [31:0] res0;
    logic [31:0] res16;
    int          count;
    logic        err;
    int          lastEdge;
  } exp_t;

  exp_t q[$];
  int   nChecks = 0;
  int   nFail = 0;
  int   cyc = 0;
  int   lastEdge = 0;

  fofb_mac_accum #(.DATA_W(32), .COEF_W(18), .ACC_W(64), .OUT_W(32), .SHIFT(0)) dut0 (
    .clk(clk), .reset(reset), .fofbCalStart(fofbCalStart), .data_valid(data_valid),
    .bpm_data(bpm_data), .coef_data(coef_data), .CalcLanth(CalcLanth),
    .result(result0), .result_valid(rv0), .sample_count(count0),
    .length_err(err0), .busy(busy0)
  );

  fofb_mac_accum #(.DATA_W(32), .COEF_W(18), .ACC_W(64), .OUT_W(32), .SHIFT(16)) dut16 (
    .clk(clk), .reset(reset), .fofbCalStart(fofbCalStart), .data_valid(data_valid),
    .bpm_data(bpm_data), .coef_data(coef_data), .CalcLanth(CalcLanth),
    .result(result16), .result_valid(rv16), .sample_count(count16),
    .length_err(err16), .busy(busy16)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic checkIdle(input string tag);
    check({tag, "_result0"}, result0, 0);
    check({tag, "_result16"}, result16, 0);
    check({tag, "_rv0"}, rv0, 0);
    check({tag, "_rv16"}, rv16, 0);
    check({tag, "_count0"}, count0, 0);
    check({tag, "_count16"}, count16, 0);
    check({tag, "_err0"}, err0, 0);
    check({tag, "_err16"}, err16, 0);
    check({tag, "_busy0"}, busy0, 0);
    check({tag, "_busy16"}, busy16, 0);
  endtask

  task automatic pulseStart();
    @(negedge clk);
    fofbCalStart = 1'b1;
    data_valid   = 1'b0;
    @(negedge clk);
    fofbCalStart = 1'b0;
  endtask

  task automatic runSamples(input int n, input int bpm, input int coef, input bit drop);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      data_valid = 1'b1;
      bpm_data   = 32'(bpm);
      coef_data  = 18'(coef);
      lastEdge   = cyc + 1;
    end
    if (drop) begin
      @(negedge clk);
      data_valid = 1'b0;
    end
  endtask

  task automatic pushExp(input logic [31:0] r0, input logic [31:0] r16, input int cnt, input logic err);
    exp_t e;
    e.res0 = r0;
    e.res16 = r16;
    e.count = cnt;
    e.err = err;
    e.lastEdge = lastEdge;
    q.push_back(e);
  endtask

  task automatic waitDrain(input string tag);
    for (int i = 0; i < 40; i++) begin
      if (q.size() == 0) break;
      @(negedge clk);
    end
    check({tag, "_drain"}, q.size(), 0);
  endtask

  // Monitor: pops one expectation per result_valid pulse and verifies the pulse is one cycle wide.
  initial begin
    exp_t e;
    bit   pulseChk = 1'b0;
    forever begin
      @(negedge clk);
      if (pulseChk) begin
        check("rv_pulse_width0", rv0, 0);
        check("rv_pulse_width16", rv16, 0);
        pulseChk = 1'b0;
      end else if (rv0 || rv16) begin
        if (q.size() == 0) begin
          nChecks++;
          nFail++;
          $display("FAIL unexpected_result_valid: got rv0=%0b rv16=%0b, expected no result (t=%0t)",
                   rv0, rv16, $time);
        end else begin
          e = q.pop_front();
          check("rv_both", {rv0, rv16}, 2'b11);
          check("result_shift0", result0, e.res0);
          check("result_shift16", result16, e.res16);
          check("sample_count0", count0, e.count);
          check("sample_count16", count16, e.count);
          check("length_err0", err0, e.err);
          check("length_err16", err16, e.err);
          check("latency", cyc - e.lastEdge, 4);
        end
        pulseChk = 1'b1;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    checkIdle("in_reset");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkIdle("after_reset");

    // Basic: 4 x 1000*2
    CalcLanth = 9'd3;
    pulseStart();
    runSamples(4, 1000, 2, 1'b1);
    pushExp(32'd8000, 32'd0, 4, 1'b0);
    waitDrain("basic");

    // Signed: 480 x -3*5 = -7200
    CalcLanth = 9'd479;
    pulseStart();
    runSamples(480, -3, 5, 1'b1);
    pushExp(32'hFFFFE3E0, 32'hFFFFFFFF, 480, 1'b0);
    waitDrain("signed");

    // Positive saturation
    CalcLanth = 9'd511;
    pulseStart();
    runSamples(512, 32'h7FFFFFFF, 32'h1FFFF, 1'b1);
    pushExp(32'h7FFFFFFF, 32'h7FFFFFFF, 512, 1'b0);
    waitDrain("sat_pos");

    // Negative saturation
    pulseStart();
    runSamples(512, 32'h7FFFFFFF, -131072, 1'b1);
    pushExp(32'h80000000, 32'h80000000, 512, 1'b0);
    waitDrain("sat_neg");

    // Length mismatch: 300 samples against an expected 360
    CalcLanth = 9'd359;
    pulseStart();
    runSamples(300, 1, 1, 1'b1);
    pushExp(32'd300, 32'd0, 300, 1'b1);
    waitDrain("len_err");

    // Correct run clears length_err; CalcLanth changes mid-run; trailing valids after a gap are ignored
    CalcLanth = 9'd5;
    pulseStart();
    runSamples(5, 2, -7, 1'b0);
    CalcLanth = 9'd9;
    runSamples(5, 2, -7, 1'b1);
    pushExp(32'hFFFFFF74, 32'hFFFFFFFF, 10, 1'b0);
    repeat (3) begin
      @(negedge clk);
      data_valid = 1'b1;
    end
    @(negedge clk);
    data_valid = 1'b0;
    waitDrain("gap");

    // Abort: restart after 100 samples, only the second run reports
    CalcLanth = 9'd9;
    pulseStart();
    runSamples(100, 1, 1, 1'b0);
    pulseStart();
    runSamples(10, 1, 1, 1'b1);
    pushExp(32'd10, 32'd0, 10, 1'b0);
    waitDrain("abort");

    // Armed with no data stays busy; then async reset mid-ACCUM
    pulseStart();
    repeat (20) @(negedge clk);
    check("armed_busy0", busy0, 1);
    check("armed_busy16", busy16, 1);
    runSamples(20, 5, 5, 1'b0);
    #2 reset = 1'b1;
    #1 checkIdle("mid_reset");
    @(negedge clk);
    data_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    runSamples(5, 1, 1, 1'b1);
    repeat (12) @(negedge clk);
    check("post_reset_busy0", busy0, 0);
    check("post_reset_busy16", busy16, 0);
    check("post_reset_count0", count0, 0);
    check("post_reset_count16", count16, 0);

    check("queue_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/fofb_mac_accum.md
Name: fofb_mac_accum

Overview:
- Multiply-accumulate stage directly downstream of the FOFB read-address controller.
- For each calculation it consumes one BPM error sample and one matrix coefficient per cycle, while the controller's valid window is open. The inputs arrive from the BPM RAM and the coefficient RAM, already aligned to the delayed address.
- Over the window it accumulates the dot product. It then produces one scaled, saturated correction word with a one-cycle valid pulse, plus a sample-count check against the programmed length.

Parameters:
- DATA_W, 32, signed BPM sample width
- COEF_W, 18, signed coefficient width
- ACC_W, 64, accumulator width; must be >= DATA_W+COEF_W+10
- OUT_W, 32, result width
- SHIFT, 16, arithmetic right shift applied to the accumulator before saturation

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  asynchronous, active-high
- fofbCalStart  in  1  start pulse/level of the calculation; rising edge arms the block
- data_valid  in  1  sample-valid window, aligned with bpm_data/coef_data
- bpm_data  in  DATA_W  signed BPM sample
- coef_data  in  COEF_W  signed coefficient
- CalcLanth  in  9  programmed last address; expected sample count = CalcLanth+1
- result  out  OUT_W  signed saturated correction value
- result_valid  out  1  one-cycle pulse when result updates
- sample_count  out  10  samples accumulated in the last/current calculation
- length_err  out  1  sticky-per-calculation: count mismatch of the last calculation
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async) values:
  - state=IDLE
  - accumulator, product register and pipeline valids = 0
  - result=0, result_valid=0, sample_count=0, length_err=0, busy=0
- Start detect: fofbCalStart is registered once. A start event is the registered value being low while the current value is high.
- States:
  - IDLE: on start event -> ARMED; clear accumulator and sample_count; clear length_err. data_valid is ignored in IDLE.
  - ARMED: first cycle with data_valid=1 -> ACCUM; that sample is captured.
  - ACCUM: every data_valid=1 cycle captures a sample. The first data_valid=0 cycle -> FLUSH.
  - FLUSH: lasts exactly 2 cycles, draining the product and accumulate stages; then -> DONE.
  - DONE: 1 cycle; result/result_valid/length_err are updated; then -> IDLE.
- Pipeline:
  - Stage 1 registers product = bpm_data*coef_data, full signed width DATA_W+COEF_W, with a valid bit.
  - Stage 2 adds the sign-extended product into the accumulator when the stage-1 valid bit is set.
  - sample_count increments at stage 2 and saturates at 1023.
  - The accumulator wraps in two's complement; ACC_W sizing prevents overflow for <=512 samples.
- Output:
  - In DONE, shifted = acc >>> SHIFT (arithmetic).
  - If shifted > 2^(OUT_W-1)-1, result = max positive; if shifted < -2^(OUT_W-1), result = min negative; otherwise result = shifted truncated to OUT_W.
  - result is held until the next DONE.
  - result_valid is high for exactly one cycle, the cycle after DONE is entered, registered together with result.
  - length_err = (sample_count != CalcLanth+1), registered with result_valid.
- Latency: the last valid sample at cycle N gives result_valid at cycle N+4.
- Boundary conditions:
  - Start event in ARMED/ACCUM/FLUSH: abort the current calculation, clear accumulator, count and pipeline, go to ARMED. No result_valid is issued for the aborted run.
  - Start event in DONE: result_valid still fires for the finishing run; the block then goes to ARMED instead of IDLE.
  - data_valid gaps: any low cycle ends accumulation. Later valid cycles are ignored until the next start event.
  - CalcLanth changing mid-calculation: the value sampled in the DONE cycle is used.
  - Reset asserted mid-operation: everything returns immediately to reset values; no result_valid.
  - Start with no data_valid ever arriving: the block stays ARMED (busy=1) until reset or the next start event.

Test Plan:
- Reset, start, 4 samples bpm=1000, coef=2, CalcLanth=3, SHIFT=0 -> result=8000, result_valid one pulse 4 cycles after the last sample, sample_count=4, length_err=0.
- Signed: bpm=-3, coef=5 for 480 samples, CalcLanth=479, SHIFT=0 -> result=-7200, length_err=0.
- Saturation: bpm=0x7FFFFFFF, coef=0x1FFFF, 512 samples, SHIFT=16 -> result=0x7FFFFFFF. Repeat with coef=-0x20000 -> result=0x80000000.
- Length mismatch: CalcLanth=359, only 300 valid samples -> sample_count=300, length_err=1. The next correct run clears length_err to 0.
- Abort: new start after 100 samples of a run -> no result_valid for the first run; the second run of 10 samples bpm=1, coef=1 -> result=10, sample_count=10.
- Async reset asserted mid-ACCUM, between clock edges -> outputs 0 and busy=0 immediately; data_valid after deassert without a start event -> no accumulation, no result_valid.
